// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, default bit period,
// byte width and a parity helper for the transmitter and receiver.
package uart_pkg;

  // Byte width of one UART character.
  localparam int unsigned C_BYTE_W = 8;

  // Default bit period minus one: 869 clocks of CLK_100M = 115200 baud.
  localparam logic [11:0] C_BIT_CNT_DEF = 12'h364;

  // One-hot transmitter states.
  typedef enum logic [4:0] {
    TX_IDLE   = 5'b00001,
    TX_START  = 5'b00010,
    TX_DATA   = 5'b00100,
    TX_PARITY = 5'b01000,
    TX_STOP   = 5'b10000
  } tx_state_t;

  // Parity bit for one character: XOR of all data bits, inverted for odd sense.
  function automatic logic f_parity(input logic [C_BYTE_W-1:0] i_data,
                                    input logic i_odd);
    return (^i_data) ^ i_odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..C_BIT_CNT while enabled and flags the last
// cycle of each bit. Held at zero while disabled so each frame starts aligned.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter logic [11:0] C_BIT_CNT = C_BIT_CNT_DEF
) (
  input  logic CLK_100M,
  input  logic IO_RESET,
  input  logic i_EN,
  output logic o_BIT_END
);

  logic [11:0] r_TX_CNT;
  logic        w_BIT_END;

  assign w_BIT_END = i_EN && (r_TX_CNT == C_BIT_CNT);
  assign o_BIT_END = w_BIT_END;

  // Advance the counter while enabled; wrap at bit end, clear when disabled.
  always_ff @(posedge CLK_100M or posedge IO_RESET) begin
    if (IO_RESET) begin
      r_TX_CNT <= '0;
    end else if (!i_EN || w_BIT_END) begin
      r_TX_CNT <= '0;
    end else begin
      r_TX_CNT <= r_TX_CNT + 12'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, idle-high line,
// with a one-byte holding buffer so consecutive frames run without a gap.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by C_PARITY_ODD)
// between the data bits and the stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [11:0] C_BIT_CNT    = C_BIT_CNT_DEF,
  parameter int unsigned C_STOP_BITS  = 1,
  parameter bit          C_PARITY_ODD = 1'b0
) (
  input  logic                CLK_100M,
  input  logic                IO_RESET,
  input  logic [C_BYTE_W-1:0] UART_TX_DATA,
  input  logic                UART_TX_VALID,
  output logic                UART_TX_READY,
  output logic                UART_TXD,
  output logic                UART_TX_BUSY,
  output logic                UART_TX_DONE
);

  localparam logic [2:0] C_LAST_BIT  = 3'(C_BYTE_W - 1);
  localparam logic [2:0] C_LAST_STOP = 3'(C_STOP_BITS - 1);

  tx_state_t           r_STATE, w_STATE_NXT;
  logic                r_TXD, w_TXD_NXT;
  logic [C_BYTE_W-1:0] r_SHIFT, w_SHIFT_NXT;
  logic [2:0]          r_BIT_IDX, w_BIT_IDX_NXT;
  logic                r_BUF_FULL, w_BUF_FULL_NXT;
  logic [C_BYTE_W-1:0] r_BUF, w_BUF_NXT;
  logic                w_HS;
  logic                w_DRAIN;
  logic                w_DONE;
  logic                w_BIT_END;
  logic                w_CNT_EN;
`ifdef UART_TX_PARITY_EN
  logic                r_PAR, w_PAR_NXT;
`endif

  assign w_HS     = UART_TX_VALID && !r_BUF_FULL;
  assign w_CNT_EN = (r_STATE != TX_IDLE);

  uart_baud_cnt #(
    .C_BIT_CNT (C_BIT_CNT)
  ) u_baud_cnt (
    .CLK_100M  (CLK_100M),
    .IO_RESET  (IO_RESET),
    .i_EN      (w_CNT_EN),
    .o_BIT_END (w_BIT_END)
  );

  // Next-state, line and datapath decode for the frame sequencer.
  // r_BIT_IDX counts data bits in DATA and is reused as the stop-bit index in STOP.
  always_comb begin
    w_STATE_NXT   = r_STATE;
    w_TXD_NXT     = r_TXD;
    w_SHIFT_NXT   = r_SHIFT;
    w_BIT_IDX_NXT = r_BIT_IDX;
    w_DRAIN       = 1'b0;
    w_DONE        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_PAR_NXT     = r_PAR;
`endif
    case (r_STATE)
      TX_IDLE: begin
        w_TXD_NXT = 1'b1;
        if (r_BUF_FULL) begin
          w_DRAIN       = 1'b1;
          w_SHIFT_NXT   = r_BUF;
          w_BIT_IDX_NXT = '0;
          w_TXD_NXT     = 1'b0;
          w_STATE_NXT   = TX_START;
`ifdef UART_TX_PARITY_EN
          w_PAR_NXT     = f_parity(r_BUF, C_PARITY_ODD);
`endif
        end
      end
      TX_START: begin
        if (w_BIT_END) begin
          w_TXD_NXT   = r_SHIFT[0];
          w_STATE_NXT = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_BIT_END) begin
          w_SHIFT_NXT = r_SHIFT >> 1;
          if (r_BIT_IDX == C_LAST_BIT) begin
            w_BIT_IDX_NXT = '0;
`ifdef UART_TX_PARITY_EN
            w_TXD_NXT     = r_PAR;
            w_STATE_NXT   = TX_PARITY;
`else
            w_TXD_NXT     = 1'b1;
            w_STATE_NXT   = TX_STOP;
`endif
          end else begin
            w_BIT_IDX_NXT = r_BIT_IDX + 3'd1;
            w_TXD_NXT     = r_SHIFT[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (w_BIT_END) begin
          w_TXD_NXT   = 1'b1;
          w_STATE_NXT = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (w_BIT_END) begin
          if (r_BIT_IDX == C_LAST_STOP) begin
            w_DONE        = 1'b1;
            w_BIT_IDX_NXT = '0;
            // A byte already waiting starts its frame straight from STOP,
            // so consecutive frames have no idle cycle between them.
            if (r_BUF_FULL) begin
              w_DRAIN     = 1'b1;
              w_SHIFT_NXT = r_BUF;
              w_TXD_NXT   = 1'b0;
              w_STATE_NXT = TX_START;
`ifdef UART_TX_PARITY_EN
              w_PAR_NXT   = f_parity(r_BUF, C_PARITY_ODD);
`endif
            end else begin
              w_TXD_NXT   = 1'b1;
              w_STATE_NXT = TX_IDLE;
            end
          end else begin
            w_BIT_IDX_NXT = r_BIT_IDX + 3'd1;
          end
        end
      end
      default: begin
        w_TXD_NXT     = 1'b1;
        w_BIT_IDX_NXT = '0;
        w_STATE_NXT   = TX_IDLE;
      end
    endcase
  end

  // Holding buffer: filled by the handshake, emptied when a frame starts.
  // Both cannot happen on one edge because READY is low while it is full.
  always_comb begin
    w_BUF_NXT      = r_BUF;
    w_BUF_FULL_NXT = r_BUF_FULL;
    if (w_DRAIN) begin
      w_BUF_FULL_NXT = 1'b0;
    end else if (w_HS) begin
      w_BUF_FULL_NXT = 1'b1;
      w_BUF_NXT      = UART_TX_DATA;
    end
  end

  // Register the sequencer state, serial line, shifter and buffer.
  always_ff @(posedge CLK_100M or posedge IO_RESET) begin
    if (IO_RESET) begin
      r_STATE    <= TX_IDLE;
      r_TXD      <= 1'b1;
      r_SHIFT    <= '0;
      r_BIT_IDX  <= '0;
      r_BUF_FULL <= 1'b0;
      r_BUF      <= '0;
`ifdef UART_TX_PARITY_EN
      r_PAR      <= 1'b0;
`endif
    end else begin
      r_STATE    <= w_STATE_NXT;
      r_TXD      <= w_TXD_NXT;
      r_SHIFT    <= w_SHIFT_NXT;
      r_BIT_IDX  <= w_BIT_IDX_NXT;
      r_BUF_FULL <= w_BUF_FULL_NXT;
      r_BUF      <= w_BUF_NXT;
`ifdef UART_TX_PARITY_EN
      r_PAR      <= w_PAR_NXT;
`endif
    end
  end

  assign UART_TXD      = r_TXD;
  assign UART_TX_READY = !r_BUF_FULL;
  assign UART_TX_BUSY  = (r_STATE != TX_IDLE);
  assign UART_TX_DONE  = w_DONE;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (10-clock bits with 1 and 2 stop bits,
// and the default 869-clock bit). Sent bytes go into a scoreboard queue; a
// line monitor pops each entry when a start bit appears and checks the frame
// start cycle, every bit cycle-by-cycle and the DONE pulse position.
module tb_uart_tx;

  typedef struct {
    logic [7:0]  d;
    int unsigned hs;
  } item_t;

  localparam int unsigned BLEN  [3] = '{10, 10, 869};
  localparam int unsigned STOPS [3] = '{1, 2, 1};
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       valid [3];
  logic       ready [3];
  logic       txd   [3];
  logic       busy  [3];
  logic       done  [3];

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int          sel = 0;
  bit          mon_en = 1'b0;
  bit          mon_busy = 1'b0;
  int unsigned prev_end = 0;
  item_t       q [$];

  uart_tx #(.C_BIT_CNT(12'h009), .C_STOP_BITS(1)) u_dut_a (
    .CLK_100M(clk), .IO_RESET(rst), .UART_TX_DATA(data), .UART_TX_VALID(valid[0]),
    .UART_TX_READY(ready[0]), .UART_TXD(txd[0]), .UART_TX_BUSY(busy[0]), .UART_TX_DONE(done[0]));

  uart_tx #(.C_BIT_CNT(12'h009), .C_STOP_BITS(2)) u_dut_b (
    .CLK_100M(clk), .IO_RESET(rst), .UART_TX_DATA(data), .UART_TX_VALID(valid[1]),
    .UART_TX_READY(ready[1]), .UART_TXD(txd[1]), .UART_TX_BUSY(busy[1]), .UART_TX_DONE(done[1]));

  uart_tx u_dut_c (
    .CLK_100M(clk), .IO_RESET(rst), .UART_TX_DATA(data), .UART_TX_VALID(valid[2]),
    .UART_TX_READY(ready[2]), .UART_TXD(txd[2]), .UART_TX_BUSY(busy[2]), .UART_TX_DONE(done[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte into instance k; returns on the negedge after the handshake.
  task automatic send(input int k, input logic [7:0] d, input bit push);
    int unsigned n = 0;
    item_t it;
    @(negedge clk);
    data = d;
    valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_handshake", ready[k], 1'b1);
    it.d  = d;
    it.hs = cyc + 1;
    if (push) q.push_back(it);
    @(negedge clk);
    valid[k] = 1'b0;
    data = 8'($urandom);
    chk("ready_low_after_handshake", ready[k], 1'b0);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while ((q.size() != 0 || mon_busy || busy[sel] !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < budget), 1'b1);
  endtask

  // Line monitor / scoreboard consumer.
  initial begin : mon
    item_t       it;
    int unsigned s, exp_s, nb;
    logic [11:0] bv;
    logic        bad, dbad, last;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && txd[sel] === 1'b0) begin
        mon_busy = 1'b1;
        s = cyc;
        chk("frame_expected", (q.size() > 0), 1'b1);
        if (q.size() > 0) begin
          it = q.pop_front();
        end else begin
          it.d  = '0;
          it.hs = s - 1;
        end
        exp_s = (it.hs + 1 > prev_end + 1) ? it.hs + 1 : prev_end + 1;
        chk($sformatf("start_cycle_%02h", it.d), s, exp_s);
        nb = 10 + PBITS + STOPS[sel] - 1;
        bv = '1;
        bv[0] = 1'b0;
        bv[8:1] = it.d;
        if (PBITS != 0) bv[9] = ^it.d;
        dbad = 1'b0;
        for (int b = 0; b < int'(nb); b++) begin
          bad = 1'b0;
          for (int c = 0; c < int'(BLEN[sel]); c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            last = (b == int'(nb) - 1) && (c == int'(BLEN[sel]) - 1);
            if (txd[sel] !== bv[b]) bad = 1'b1;
            if (done[sel] !== last) dbad = 1'b1;
          end
          chk($sformatf("bit%0d_of_%02h", b, it.d), bad, 1'b0);
        end
        chk($sformatf("done_pulse_%02h", it.d), dbad, 1'b0);
        prev_end = cyc;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stim
    logic bad;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_txd_%0d", k), txd[k], 1'b1);
      chk($sformatf("reset_ready_%0d", k), ready[k], 1'b1);
      chk($sformatf("reset_busy_%0d", k), busy[k], 1'b0);
      chk($sformatf("reset_done_%0d", k), done[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Single byte, READY returns one cycle after the frame starts.
    sel = 0;
    send(0, 8'h55, 1'b1);
    @(negedge clk);
    chk("ready_after_load", ready[0], 1'b1);
    chk("busy_in_frame", busy[0], 1'b1);
    wait_done(300);

    // Back-to-back bytes: second VALID held until READY.
    send(0, 8'hA3, 1'b1);
    send(0, 8'h0F, 1'b1);
    wait_done(600);

    // Parity-relevant byte followed by a short random burst.
    send(0, 8'h07, 1'b1);
    for (int i = 0; i < 3; i++) send(0, 8'($urandom), 1'b1);
    wait_done(1000);

    // Reset in the middle of frame 0x81 (frame cycle 45 sits in a low data bit).
    mon_en = 1'b0;
    send(0, 8'h81, 1'b0);
    repeat (45) @(negedge clk);
    chk("txd_before_reset", txd[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("txd_async_reset", txd[0], 1'b1);
    chk("busy_async_reset", busy[0], 1'b0);
    chk("done_async_reset", done[0], 1'b0);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || txd[0] !== 1'b1) bad = 1'b1;
    end
    chk("line_held_in_reset", bad, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready[0], 1'b1);
    chk("busy_after_reset", busy[0], 1'b0);
    mon_en = 1'b1;
    send(0, 8'h3C, 1'b1);
    wait_done(300);

    // Two stop bits.
    sel = 1;
    send(1, 8'hFF, 1'b1);
    wait_done(300);

    // Default bit period.
    sel = 2;
    send(2, 8'h00, 1'b1);
    wait_done(12000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
